// File: rtl/mdu_pkg.sv
// Shared encodings, latency defaults and counter sizing for the multiply/divide unit.
// The MDU_DIV0_HOLD_EN build option is handled in mdu_arith.
package mdu_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_op_e;

    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    localparam int MULT_CYCLES_DEF = 32'sd5;
    localparam int DIV_CYCLES_DEF  = 32'sd10;

    // Counter must hold the larger latency as a plain count.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m) + 32'sd1;
    endfunction

    localparam int MD_CNT_W = cnt_width(MULT_CYCLES_DEF, DIV_CYCLES_DEF);

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath: {hi, lo} plus a write-back qualifier for one op.
// MDU_DIV0_HOLD_EN: when defined, divide-by-zero suppresses write-back instead of the LO=all-ones / HI=rs pattern.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        wr_en
);

    logic [63:0] prod_signed_s;
    logic [63:0] prod_unsigned_s;
    logic [31:0] rs_mag_s;
    logic [31:0] rt_mag_s;
    logic        rt_zero_s;
    logic [31:0] sden_s;
    logic [31:0] uden_s;
    logic [31:0] sq_mag_s;
    logic [31:0] sr_mag_s;
    logic [31:0] sq_s;
    logic [31:0] sr_s;
    logic [31:0] uq_s;
    logic [31:0] ur_s;

    assign prod_signed_s   = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    assign prod_unsigned_s = {32'd0, rs} * {32'd0, rt};

    // Signed divide runs on magnitudes; 0x80000000 / -1 wraps back to 0x80000000 with remainder 0.
    assign rs_mag_s  = rs[31] ? (32'd0 - rs) : rs;
    assign rt_mag_s  = rt[31] ? (32'd0 - rt) : rt;
    assign rt_zero_s = (rt == 32'd0);

    // Divisor forced to 1 on zero so the dividers always see a defined operand.
    assign sden_s   = rt_zero_s ? 32'd1 : rt_mag_s;
    assign uden_s   = rt_zero_s ? 32'd1 : rt;
    assign sq_mag_s = rs_mag_s / sden_s;
    assign sr_mag_s = rs_mag_s % sden_s;
    assign sq_s     = (rs[31] ^ rt[31]) ? (32'd0 - sq_mag_s) : sq_mag_s;
    assign sr_s     = rs[31] ? (32'd0 - sr_mag_s) : sr_mag_s;
    assign uq_s     = rs / uden_s;
    assign ur_s     = rs % uden_s;

    // Result select per op, including the divide-by-zero policy.
    always_comb begin
        hi    = 32'd0;
        lo    = 32'd0;
        wr_en = 1'b1;
        case (op)
            MD_MULT: begin
                hi = prod_signed_s[63:32];
                lo = prod_signed_s[31:0];
            end
            MD_MULTU: begin
                hi = prod_unsigned_s[63:32];
                lo = prod_unsigned_s[31:0];
            end
            MD_DIV, MD_DIVU: begin
                if (rt_zero_s) begin
`ifdef MDU_DIV0_HOLD_EN
                    wr_en = 1'b0;
`else
                    hi = rs;
                    lo = 32'hFFFF_FFFF;
`endif
                end else if (op == MD_DIV) begin
                    hi = sr_s;
                    lo = sq_s;
                end else begin
                    hi = ur_s;
                    lo = uq_s;
                end
            end
            default: begin
                hi    = 32'd0;
                lo    = 32'd0;
                wr_en = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_sched.sv
// Multiply/divide unit sequencer: owns HI/LO, runs fixed-latency mult/div and raises the D-stage stall.
// Divide-by-zero write-back depends on MDU_DIV0_HOLD_EN (see mdu_arith).
module mdu_sched
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op_E,
    input  logic        op_valid_E,
    input  logic [31:0] rs_E,
    input  logic [31:0] rt_E,
    input  logic        md_use_D,
    output logic [31:0] md_rdata_E,
    output logic        start,
    output logic        busy,
    output logic        stall_md
);

    localparam int CNT_REQ_W = cnt_width(MULT_CYCLES, DIV_CYCLES);
    localparam int CNT_W     = (CNT_REQ_W > MD_CNT_W) ? CNT_REQ_W : MD_CNT_W;

    md_state_e        state_r;
    logic             busy_r;
    logic [CNT_W-1:0] cnt_r;
    logic [31:0]      hi_r;
    logic [31:0]      lo_r;
    logic [31:0]      pend_hi_r;
    logic [31:0]      pend_lo_r;
    logic             pend_wr_r;

    logic             is_long_s;
    logic             is_mult_s;
    logic             start_s;
    logic [31:0]      ar_hi_s;
    logic [31:0]      ar_lo_s;
    logic             ar_wr_s;

    mdu_arith u_arith (
        .op    (md_op_E),
        .rs    (rs_E),
        .rt    (rt_E),
        .hi    (ar_hi_s),
        .lo    (ar_lo_s),
        .wr_en (ar_wr_s)
    );

    // Classify the E-stage op as a multi-cycle launch candidate.
    always_comb begin
        is_long_s = 1'b0;
        is_mult_s = 1'b0;
        case (md_op_E)
            MD_MULT, MD_MULTU: begin
                is_long_s = 1'b1;
                is_mult_s = 1'b1;
            end
            MD_DIV, MD_DIVU: begin
                is_long_s = 1'b1;
                is_mult_s = 1'b0;
            end
            default: begin
                is_long_s = 1'b0;
                is_mult_s = 1'b0;
            end
        endcase
    end

    assign start_s  = op_valid_E & is_long_s & ~busy_r;
    assign start    = start_s;
    assign busy     = busy_r;
    assign stall_md = md_use_D & (start_s | busy_r);

    // HI/LO read port; shows the registered values only, never a same-cycle move.
    always_comb begin
        md_rdata_E = 32'd0;
        if (op_valid_E && (md_op_E == MD_MFHI)) begin
            md_rdata_E = hi_r;
        end else if (op_valid_E && (md_op_E == MD_MFLO)) begin
            md_rdata_E = lo_r;
        end else begin
            md_rdata_E = 32'd0;
        end
    end

    // Sequencer: launch captures the result, the counter times the busy window, completion commits HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= MD_IDLE;
            busy_r    <= 1'b0;
            cnt_r     <= '0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            pend_hi_r <= 32'd0;
            pend_lo_r <= 32'd0;
            pend_wr_r <= 1'b0;
        end else begin
            case (state_r)
                MD_IDLE: begin
                    if (start_s) begin
                        pend_hi_r <= ar_hi_s;
                        pend_lo_r <= ar_lo_s;
                        pend_wr_r <= ar_wr_s;
                        cnt_r     <= is_mult_s ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                        busy_r    <= 1'b1;
                        state_r   <= MD_BUSY;
                    end else if (op_valid_E && (md_op_E == MD_MTHI)) begin
                        hi_r <= rs_E;
                    end else if (op_valid_E && (md_op_E == MD_MTLO)) begin
                        lo_r <= rs_E;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                MD_BUSY: begin
                    if (cnt_r == CNT_W'(1)) begin
                        if (pend_wr_r) begin
                            hi_r <= pend_hi_r;
                            lo_r <= pend_lo_r;
                        end else begin
                            hi_r <= hi_r;
                        end
                        cnt_r   <= '0;
                        busy_r  <= 1'b0;
                        state_r <= MD_IDLE;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    cnt_r   <= '0;
                    busy_r  <= 1'b0;
                    state_r <= MD_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_sched.sv
// Self-checking bench for mdu_sched: directed vector table, hand sequences and a random run
// against a cycle-level reference model built from plain 64-bit arithmetic.
module tb_mdu_sched;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;
    localparam int N_MULT = 5;
    localparam int N_DIV  = 10;
    localparam int NV     = 12;
    localparam logic [31:0] PRE_HI = 32'h0BAD_0001;
    localparam logic [31:0] PRE_LO = 32'h0BAD_0002;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [3:0]  md_op_E;
    logic        op_valid_E;
    logic [31:0] rs_E;
    logic [31:0] rt_E;
    logic        md_use_D;
    logic [31:0] md_rdata_E;
    logic        start;
    logic        busy;
    logic        stall_md;

    int total;
    int bad;

    // reference model state: architectural HI/LO plus an in-flight result and cycles left
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    logic        m_pwr;
    int          m_left;

    // values sampled during the most recent cycle
    logic        s_start, s_busy, s_stall;
    logic [31:0] s_rdata;

    vec_t vecs [NV];

    mdu_sched dut (
        .clk        (clk),
        .reset      (reset),
        .md_op_E    (md_op_E),
        .op_valid_E (op_valid_E),
        .rs_E       (rs_E),
        .rt_E       (rt_E),
        .md_use_D   (md_use_D),
        .md_rdata_E (md_rdata_E),
        .start      (start),
        .busy       (busy),
        .stall_md   (stall_md)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    function automatic logic is_long(input logic [3:0] op);
        return (op >= OP_MULT) && (op <= OP_DIVU);
    endfunction

    // {write, hi, lo} straight from the arithmetic definitions
    function automatic logic [64:0] ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, p, q, r;
        longint unsigned ua, ub, up, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if ((op == OP_DIV || op == OP_DIVU) && b == 32'd0) begin
`ifdef MDU_DIV0_HOLD_EN
            return {1'b0, 64'd0};
`else
            return {1'b1, a, 32'hFFFF_FFFF};
`endif
        end
        case (op)
            OP_MULT:  begin p = sa * sb; return {1'b1, p[63:0]}; end
            OP_MULTU: begin up = ua * ub; return {1'b1, up[63:0]}; end
            OP_DIV:   begin q = sa / sb; r = sa % sb; return {1'b1, r[31:0], q[31:0]}; end
            OP_DIVU:  begin uq = ua / ub; ur = ua % ub; return {1'b1, ur[31:0], uq[31:0]}; end
            default:  return {1'b0, 64'd0};
        endcase
    endfunction

    task automatic model_reset();
        m_hi = 32'd0; m_lo = 32'd0; m_phi = 32'd0; m_plo = 32'd0;
        m_pwr = 1'b0; m_left = 0;
    endtask

    task automatic model_step();
        logic [64:0] res;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_pwr) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (op_valid_E && is_long(md_op_E)) begin
            res    = ref_op(md_op_E, rs_E, rt_E);
            m_pwr  = res[64];
            m_phi  = res[63:32];
            m_plo  = res[31:0];
            m_left = (md_op_E == OP_MULT || md_op_E == OP_MULTU) ? N_MULT : N_DIV;
        end else if (op_valid_E && md_op_E == OP_MTHI) begin
            m_hi = rs_E;
        end else if (op_valid_E && md_op_E == OP_MTLO) begin
            m_lo = rs_E;
        end
    endtask

    // one clock: drive, compare every output with the model, advance the model, step past the edge
    task automatic cyc(input logic [3:0] op, input logic v, input logic [31:0] a,
                       input logic [31:0] b, input logic ud);
        logic        e_start;
        logic [31:0] e_rd;
        md_op_E = op; op_valid_E = v; rs_E = a; rt_E = b; md_use_D = ud;
        #1;
        e_start = v && is_long(op) && (m_left == 0);
        e_rd    = !v ? 32'd0 : (op == OP_MFHI) ? m_hi : (op == OP_MFLO) ? m_lo : 32'd0;
        s_start = start; s_busy = busy; s_stall = stall_md; s_rdata = md_rdata_E;
        check1("start", start, e_start);
        check1("busy", busy, m_left > 0);
        check1("stall_md", stall_md, ud && (e_start || m_left > 0));
        check("md_rdata_E", md_rdata_E, e_rd);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b1;
        md_op_E = OP_NONE; op_valid_E = 1'b0; rs_E = 32'd0; rt_E = 32'd0; md_use_D = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int          n;
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        total = 0;
        bad   = 0;
        model_reset();
        apply_reset(3);

        // reset state
        cyc(OP_NONE, 1'b0, 32'd0, 32'd0, 1'b1);
        check1("rst_busy", s_busy, 1'b0);
        check1("rst_stall", s_stall, 1'b0);
        check1("rst_start", s_start, 1'b0);
        cyc(OP_MFHI, 1'b1, 32'd0, 32'd0, 1'b1);
        check("rst_hi", s_rdata, 32'd0);
        cyc(OP_MFLO, 1'b1, 32'd0, 32'd0, 1'b0);
        check("rst_lo", s_rdata, 32'd0);

        vecs[0]  = '{OP_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, N_MULT};
        vecs[1]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, N_MULT};
        vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, N_DIV};
        vecs[3]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, N_DIV};
        vecs[4]  = '{OP_DIV,   32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, N_DIV};
        vecs[5]  = '{OP_DIVU,  32'd100,      32'd7,        32'h0000_0002, 32'h0000_000E, N_DIV};
        vecs[6]  = '{OP_DIVU,  32'hFFFF_FFFF, 32'h10,       32'h0000_000F, 32'h0FFF_FFFF, N_DIV};
        vecs[7]  = '{OP_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, N_MULT};
`ifdef MDU_DIV0_HOLD_EN
        vecs[8]  = '{OP_DIVU,  32'h1234_5678, 32'd0,        PRE_HI,        PRE_LO,        N_DIV};
        vecs[9]  = '{OP_DIV,   32'hFFFF_FFFB, 32'd0,        PRE_HI,        PRE_LO,        N_DIV};
`else
        vecs[8]  = '{OP_DIVU,  32'h1234_5678, 32'd0,        32'h1234_5678, 32'hFFFF_FFFF, N_DIV};
        vecs[9]  = '{OP_DIV,   32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, N_DIV};
`endif
        vecs[10] = '{OP_MULT,  32'h8000_0000, 32'd1,        32'hFFFF_FFFF, 32'h8000_0000, N_MULT};
        vecs[11] = '{OP_MULTU, 32'h8000_0000, 32'd1,        32'h0000_0000, 32'h8000_0000, N_MULT};

        // table: preset HI/LO, launch, count busy cycles, read results on the first free cycle
        for (int i = 0; i < NV; i++) begin
            cyc(OP_MTHI, 1'b1, PRE_HI, 32'd0, 1'b0);
            cyc(OP_MTLO, 1'b1, PRE_LO, 32'd0, 1'b0);
            cyc(vecs[i].op, 1'b1, vecs[i].rs, vecs[i].rt, 1'b0);
            check1("vec_start", s_start, 1'b1);
            n = 0;
            while (busy === 1'b1 && n < 40) begin
                cyc(OP_NONE, 1'b0, 32'd0, 32'd0, 1'b0);
                n++;
            end
            check("vec_latency", 32'(n), 32'(vecs[i].lat));
            cyc(OP_MFHI, 1'b1, 32'd0, 32'd0, 1'b0);
            check("vec_hi", s_rdata, vecs[i].hi);
            cyc(OP_MFLO, 1'b1, 32'd0, 32'd0, 1'b0);
            check("vec_lo", s_rdata, vecs[i].lo);
        end

        // mult with an MDU op waiting in D: stall for launch + 5 busy cycles
        cyc(OP_MULT, 1'b1, 32'd5, 32'd6, 1'b1);
        check1("stall_launch", s_stall, 1'b1);
        for (int k = 0; k < N_MULT; k++) begin
            cyc(OP_NONE, 1'b0, 32'd0, 32'd0, 1'b1);
            check1("stall_busy", s_stall, 1'b1);
        end
        cyc(OP_NONE, 1'b0, 32'd0, 32'd0, 1'b1);
        check1("stall_after", s_stall, 1'b0);

        // same mult with a non-MDU op in D never stalls
        cyc(OP_MULT, 1'b1, 32'd5, 32'd6, 1'b0);
        for (int k = 0; k < N_MULT + 1; k++) begin
            cyc(OP_NONE, 1'b0, 32'd0, 32'd0, 1'b0);
            check1("nostall", s_stall, 1'b0);
        end

        // ops presented while busy are ignored; reads return the old HI
        cyc(OP_MTHI, 1'b1, 32'hCAFE_0001, 32'd0, 1'b0);
        cyc(OP_MULT, 1'b1, 32'd2, 32'd3, 1'b0);
        cyc(OP_MTHI, 1'b1, 32'hDEAD_BEEF, 32'd0, 1'b1);
        check1("busy_stall", s_stall, 1'b1);
        cyc(OP_MFHI, 1'b1, 32'd0, 32'd0, 1'b0);
        check("busy_old_hi", s_rdata, 32'hCAFE_0001);
        cyc(OP_DIV, 1'b1, 32'd9, 32'd3, 1'b0);
        check1("busy_no_start", s_start, 1'b0);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            cyc(OP_NONE, 1'b0, 32'd0, 32'd0, 1'b0);
            n++;
        end
        cyc(OP_MFHI, 1'b1, 32'd0, 32'd0, 1'b0);
        check("busy_new_hi", s_rdata, 32'd0);
        cyc(OP_MFLO, 1'b1, 32'd0, 32'd0, 1'b0);
        check("busy_new_lo", s_rdata, 32'd6);

        // reset in busy cycle 3 of a divu discards the pending result
        cyc(OP_MTHI, 1'b1, 32'h1111_1111, 32'd0, 1'b0);
        cyc(OP_MTLO, 1'b1, 32'h2222_2222, 32'd0, 1'b0);
        cyc(OP_DIVU, 1'b1, 32'd100, 32'd7, 1'b0);
        cyc(OP_NONE, 1'b0, 32'd0, 32'd0, 1'b0);
        cyc(OP_NONE, 1'b0, 32'd0, 32'd0, 1'b0);
        apply_reset(1);
        cyc(OP_MFHI, 1'b1, 32'd0, 32'd0, 1'b1);
        check1("midrst_busy", s_busy, 1'b0);
        check1("midrst_stall", s_stall, 1'b0);
        check("midrst_hi", s_rdata, 32'd0);
        for (int k = 0; k < 12; k++) cyc(OP_NONE, 1'b0, 32'd0, 32'd0, 1'b0);
        cyc(OP_MFLO, 1'b1, 32'd0, 32'd0, 1'b0);
        check("midrst_lo", s_rdata, 32'd0);

        // mtlo then mflo
        cyc(OP_MTLO, 1'b1, 32'h0000_1234, 32'd0, 1'b0);
        cyc(OP_MFLO, 1'b1, 32'd0, 32'd0, 1'b0);
        check("mtlo_mflo", s_rdata, 32'h0000_1234);

        // bubbles do nothing
        cyc(OP_MTHI, 1'b1, 32'h0000_00AB, 32'd0, 1'b0);
        cyc(OP_MTHI, 1'b0, 32'h0000_0099, 32'd0, 1'b0);
        cyc(OP_MULT, 1'b0, 32'd3, 32'd3, 1'b1);
        check1("bubble_start", s_start, 1'b0);
        check1("bubble_stall", s_stall, 1'b0);
        cyc(OP_MFHI, 1'b0, 32'd0, 32'd0, 1'b0);
        check1("bubble_busy", s_busy, 1'b0);
        check("bubble_rd", s_rdata, 32'd0);
        cyc(OP_MFHI, 1'b1, 32'd0, 32'd0, 1'b0);
        check("bubble_hi", s_rdata, 32'h0000_00AB);

        // random traffic against the model
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 249) == 32'd0) begin
                apply_reset(1);
            end else begin
                rop = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 2) == 32'd0) rop = 4'($urandom_range(5, 8));
                ra = $urandom;
                if ($urandom_range(0, 7) == 32'd0) ra = 32'h8000_0000;
                case ($urandom_range(0, 7))
                    32'd0:   rb = 32'd0;
                    32'd1:   rb = 32'hFFFF_FFFF;
                    32'd2:   rb = 32'd1;
                    default: rb = $urandom;
                endcase
                cyc(rop, $urandom_range(0, 7) != 32'd0, ra, rb, $urandom_range(0, 1) != 32'd0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
